// File: rtl/uart_link_pkg.sv
// -----------------------------------------------------------------------------
// uart_link_pkg
// Shared definitions for the UART link arbiter:
//   - link_state_t : arbiter FSM state encoding
//   - frame field positions inside the 32-bit TX frame
//   - default widths / counts used as parameter defaults
//   - idx_width()  : width of an index into an N-entry vector (min 1)
// -----------------------------------------------------------------------------
package uart_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_TXWAIT = 2'd2,
        ST_RXWAIT = 2'd3
    } link_state_t;

    // TX frame layout: [11:0] addr, [19:12] wdata, [20] mode (1 = write)
    localparam int ADDR_LSB  = 0;
    localparam int ADDR_W    = 12;
    localparam int WDATA_LSB = 12;
    localparam int WDATA_W   = 8;
    localparam int MODE_BIT  = 20;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_FRAME_WIDTH    = 32;
    localparam int DEF_RESP_WIDTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 100000;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_link_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin search: returns the first asserted request at or
// after the pointer, wrapping around the vector.
// Ports:
//   req_i     [N-1:0]  request vector
//   ptr_i     [IW-1:0] search start position (must be < N)
//   gnt_o     [N-1:0]  one-hot grant (all zero when no request)
//   idx_o     [IW-1:0] index of the granted request
//   any_req_o          at least one request asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_req_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int PW = IW + 1;

    logic [PW-1:0] pos;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr_i} + PW'(k);
            if (pos >= PW'(N)) begin
                pos = pos - PW'(N);
            end
            if (!found && req_i[pos[IW-1:0]]) begin
                gnt_o[pos[IW-1:0]] = 1'b1;
                idx_o              = pos[IW-1:0];
                found              = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/uart_link_arbiter.sv
// -----------------------------------------------------------------------------
// uart_link_arbiter
// Shares one UART link between NUM_REQ bridge slave front-ends. The link is
// granted round-robin; the winning frame is launched with a one-cycle u_en and
// the arbiter waits for TX to finish. Read frames additionally hold the link
// until a fresh RX response arrives, which is steered back to the owner.
//
// Optional feature (macro UART_RESP_TIMEOUT_EN): read-response timeout after
// TIMEOUT_CYCLES cycles in RXWAIT, reported through resp_err. Without the
// macro RXWAIT waits indefinitely and resp_err is constant 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       per-requester frame pending (held until accepted)
//   req_frame       packed frames, requester i at [i*FRAME_WIDTH +: FRAME_WIDTH]
//   req_accept      one-cycle pulse when the requester's frame was latched
//                   (coincides with u_en)
//   req_done        one-cycle pulse when a write frame has finished TX
//   resp_valid      one-cycle pulse when a read response is available
//   resp_err        one-cycle pulse on read-response timeout
//   resp_data       last read response (shared), valid with resp_valid
//   u_din, u_en     frame and start pulse to the UART TX
//   u_tx_busy       UART TX busy
//   u_rx_ready      UART RX data ready (level)
//   u_dout          UART RX data
//   link_busy       arbiter is not idle
// -----------------------------------------------------------------------------
module uart_link_arbiter
    import uart_link_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int FRAME_WIDTH    = DEF_FRAME_WIDTH,
    parameter int RESP_WIDTH     = DEF_RESP_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_frame,
    output logic [NUM_REQ-1:0]             req_accept,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [NUM_REQ-1:0]             resp_err,
    output logic [RESP_WIDTH-1:0]          resp_data,
    output logic [FRAME_WIDTH-1:0]         u_din,
    output logic                           u_en,
    input  logic                           u_tx_busy,
    input  logic                           u_rx_ready,
    input  logic [RESP_WIDTH-1:0]          u_dout,
    output logic                           link_busy
);

    localparam int IW = idx_width(NUM_REQ);

    // ------------------------------------------------------------------
    // Frame unpacking
    // ------------------------------------------------------------------
    logic [FRAME_WIDTH-1:0] frame_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign frame_arr[gi] = req_frame[gi*FRAME_WIDTH +: FRAME_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    link_state_t            state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic                   is_wr_q, is_wr_d;
    logic                   tx_seen_q, tx_seen_d;
    logic                   rx_prev_q;
    logic [FRAME_WIDTH-1:0] u_din_q, u_din_d;
    logic [RESP_WIDTH-1:0]  resp_data_q, resp_data_d;
    logic [NUM_REQ-1:0]     accept_q, accept_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;

`ifdef UART_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     err_q, err_d;
`endif

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               any_req;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .idx_o     (gnt_idx),
        .any_req_o (any_req)
    );

    logic [NUM_REQ-1:0] owner_oh;
    logic               rx_rise;

    assign owner_oh = NUM_REQ'(1) << owner_q;
    // rx_prev tracks the ready level every cycle, so a level that is already
    // high when RXWAIT is entered never looks like a rising edge.
    assign rx_rise  = u_rx_ready & ~rx_prev_q;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        is_wr_d     = is_wr_q;
        tx_seen_d   = tx_seen_q;
        u_din_d     = u_din_q;
        resp_data_d = resp_data_q;
        accept_d    = '0;
        done_d      = '0;
        rvalid_d    = '0;
`ifdef UART_RESP_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = '0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    u_din_d  = frame_arr[gnt_idx];
                    owner_d  = gnt_idx;
                    is_wr_d  = frame_arr[gnt_idx][MODE_BIT];
                    accept_d = gnt;
                    rr_ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
                    state_d  = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                tx_seen_d = 1'b0;
                state_d   = ST_TXWAIT;
            end

            ST_TXWAIT: begin
                // Completion requires busy to have been seen first, so the
                // cycles before the UART raises busy are not mistaken for done.
                if (u_tx_busy) begin
                    tx_seen_d = 1'b1;
                end else if (tx_seen_q) begin
                    if (is_wr_q) begin
                        done_d  = owner_oh;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RXWAIT;
`ifdef UART_RESP_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end

            ST_RXWAIT: begin
                if (rx_rise) begin
                    resp_data_d = u_dout;
                    rvalid_d    = owner_oh;
                    state_d     = ST_IDLE;
                end
`ifdef UART_RESP_TIMEOUT_EN
                // A response in the timeout cycle takes priority (checked above).
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = owner_oh;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            is_wr_q     <= 1'b0;
            tx_seen_q   <= 1'b0;
            rx_prev_q   <= 1'b0;
            u_din_q     <= '0;
            resp_data_q <= '0;
            accept_q    <= '0;
            done_q      <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            is_wr_q     <= is_wr_d;
            tx_seen_q   <= tx_seen_d;
            rx_prev_q   <= u_rx_ready;
            u_din_q     <= u_din_d;
            resp_data_q <= resp_data_d;
            accept_q    <= accept_d;
            done_q      <= done_d;
            rvalid_q    <= rvalid_d;
        end
    end

`ifdef UART_RESP_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign resp_err = err_q;
`else
    assign resp_err = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // u_en is decoded from the state register so reset removes it at once.
    assign u_en       = (state_q == ST_LAUNCH);
    assign link_busy  = (state_q != ST_IDLE);
    assign u_din      = u_din_q;
    assign resp_data  = resp_data_q;
    assign req_accept = accept_q;
    assign req_done   = done_q;
    assign resp_valid = rvalid_q;

endmodule

// File: tb/tb_uart_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_link_arbiter
// Directed bench for uart_link_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=50).
// A small UART TX model raises busy one cycle after u_en for busy_len cycles.
// Build with +define+UART_RESP_TIMEOUT_EN to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_uart_link_arbiter;
    import uart_link_pkg::*;

    localparam int NR = 2;
    localparam int FW = 32;
    localparam int RW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*FW-1:0] req_frame = '0;
    logic [NR-1:0]    req_accept, req_done, resp_valid, resp_err;
    logic [RW-1:0]    resp_data;
    logic [FW-1:0]    u_din;
    logic             u_en;
    logic             u_tx_busy = 1'b0;
    logic             u_rx_ready = 1'b0;
    logic [RW-1:0]    u_dout = '0;
    logic             link_busy;

    uart_link_arbiter #(
        .NUM_REQ        (NR),
        .FRAME_WIDTH    (FW),
        .RESP_WIDTH     (RW),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_frame  (req_frame),
        .req_accept (req_accept),
        .req_done   (req_done),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_data  (resp_data),
        .u_din      (u_din),
        .u_en       (u_en),
        .u_tx_busy  (u_tx_busy),
        .u_rx_ready (u_rx_ready),
        .u_dout     (u_dout),
        .link_busy  (link_busy)
    );

    initial forever #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          busy_len = 10;
    int          fall_cyc = 0;
    int          fall_cnt = 0;
    int          en_cnt   = 0;
    int          en_cyc_q[$];
    logic [31:0] en_din_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [1:0]  done_vec = '0;
    int          rv_cnt   = 0;
    int          err_cnt  = 0;
    int          err_cyc  = 0;
    logic [1:0]  err_vec  = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_frame(input logic [11:0] addr, input logic [7:0] wdata, input logic wr);
        logic [31:0] f;
        f = '0;
        f[ADDR_LSB +: ADDR_W]   = addr;
        f[WDATA_LSB +: WDATA_W] = wdata;
        f[MODE_BIT]             = wr;
        return f;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART TX model
    initial forever begin
        @(negedge clk);
        if (u_en) begin
            @(negedge clk);
            u_tx_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            u_tx_busy = 1'b0;
            fall_cyc  = cyc;
            fall_cnt++;
        end
    end

    // Output monitor
    initial forever begin
        @(negedge clk);
        if (u_en) begin
            en_cnt++;
            en_cyc_q.push_back(cyc);
            en_din_q.push_back(u_din);
        end
        if (|req_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_vec = req_done;
        end
        if (|resp_valid) rv_cnt++;
        if (|resp_err) begin
            err_cnt++;
            err_cyc = cyc;
            err_vec = resp_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int          f0;
        int          dbase;
        int          ebase;
        int          left [NR];
        int          fc;
        logic [31:0] din_tmp;

        // Reset
        repeat (3) tick();
        check_eq("rst_accept", req_accept, 0);
        check_eq("rst_u_en", u_en, 0);
        check_eq("rst_link_busy", link_busy, 0);
        check_eq("rst_u_din", u_din, 0);
        check_eq("rst_resp_data", resp_data, 0);
        rst = 1'b0;
        tick();

        // Single write from requester 0
        $display("txn write req0 frame=0x001a5123");
        req_frame[0 +: FW] = 32'h001A5123;
        req_valid = 2'b01;
        tick();
        check_eq("wr_accept", req_accept, 2'b01);
        check_eq("wr_u_en", u_en, 1);
        check_eq("wr_u_din", u_din, 32'h001A5123);
        req_valid = '0;
        tick();
        check_eq("wr_u_en_single", u_en, 0);
        for (int k = 0; k < 100 && done_cnt == 0; k++) tick();
        check_eq("wr_done_seen", done_cnt, 1);
        check_eq("wr_done_vec", done_vec, 2'b01);
        check_eq("wr_done_latency", done_cyc - fall_cyc, 1);
        check_eq("wr_no_resp", rv_cnt, 0);
        check_eq("wr_en_count", en_cnt, 1);
        check_eq("wr_idle", link_busy, 0);

        // Single read from requester 1
        $display("txn read req1 frame=0x00000456 resp=0x00c3");
        req_frame[FW +: FW] = 32'h00000456;
        req_valid = 2'b10;
        tick();
        check_eq("rd_accept", req_accept, 2'b10);
        check_eq("rd_u_din", u_din, 32'h00000456);
        req_valid = '0;
        f0 = fall_cnt;
        for (int k = 0; k < 100 && fall_cnt == f0; k++) tick();
        repeat (3) tick();
        check_eq("rd_hold_link", link_busy, 1);
        check_eq("rd_no_early_resp", rv_cnt, 0);
        u_dout = 16'h00C3;
        u_rx_ready = 1'b1;
        tick();
        check_eq("rd_resp_valid", resp_valid, 2'b10);
        check_eq("rd_resp_data", resp_data, 16'h00C3);
        u_rx_ready = 1'b0;
        tick();
        check_eq("rd_idle", link_busy, 0);
        check_eq("rd_resp_count", rv_cnt, 1);
        check_eq("rd_no_done", done_cnt, 1);

        // Contention: both requesters, two writes each
        busy_len = 4;
        ebase = en_cnt;
        dbase = done_cnt;
        left[0] = 2;
        left[1] = 2;
        req_frame[0 +: FW]  = mk_frame(12'h000, 8'h30, 1'b1);
        req_frame[FW +: FW] = mk_frame(12'h001, 8'h40, 1'b1);
        req_valid = 2'b11;
        for (int k = 0; k < 400 && done_cnt < dbase + 4; k++) begin
            tick();
            for (int i = 0; i < NR; i++) begin
                if (req_accept[i]) begin
                    $display("txn contention accept req%0d frame=0x%08h", i, u_din);
                    left[i]--;
                    if (left[i] == 0) req_valid[i] = 1'b0;
                    else req_frame[i*FW +: FW] = mk_frame(12'(i), 8'h50, 1'b1);
                end
            end
        end
        check_eq("cont_done_count", done_cnt, dbase + 4);
        for (int j = 0; j < 4; j++) begin
            din_tmp = en_din_q[ebase + j];
            check_eq($sformatf("cont_order_%0d", j), din_tmp[11:0], j % 2);
        end
        for (int j = 1; j < 4; j++) begin
            check_eq($sformatf("cont_en_gap_%0d", j), en_cyc_q[ebase + j] - en_cyc_q[ebase + j - 1], 7);
        end
        req_valid = '0;
        repeat (2) tick();

        // Async reset during TXWAIT
        busy_len = 10;
        $display("txn write req0 with reset in TXWAIT");
        req_frame[0 +: FW] = mk_frame(12'h0AB, 8'h5A, 1'b1);
        req_valid = 2'b01;
        tick();
        check_eq("rst_txn_accept", req_accept, 2'b01);
        req_valid = '0;
        for (int k = 0; k < 20 && !u_tx_busy; k++) tick();
        check_eq("rst_txn_busy_seen", u_tx_busy, 1);
        tick();
        dbase = done_cnt;
        #3 rst = 1'b1;
        #1;
        check_eq("arst_link_busy", link_busy, 0);
        check_eq("arst_u_en", u_en, 0);
        check_eq("arst_u_din", u_din, 0);
        check_eq("arst_done", req_done, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 40 && u_tx_busy; k++) tick();
        repeat (3) tick();
        check_eq("arst_no_done", done_cnt, dbase);
        $display("txn both requesters after reset");
        req_frame[0 +: FW]  = mk_frame(12'h0C0, 8'h11, 1'b1);
        req_frame[FW +: FW] = mk_frame(12'h0C1, 8'h22, 1'b1);
        req_valid = 2'b11;
        tick();
        check_eq("arst_ptr_zero", req_accept, 2'b01);
        check_eq("arst_u_din_new", u_din, 32'h0011_10C0);
        req_valid = '0;
        for (int k = 0; k < 100 && done_cnt == dbase; k++) tick();
        check_eq("arst_done_vec", done_vec, 2'b01);
        tick();

        // Stale ready on RXWAIT entry
        $display("txn read req1 with stale rx_ready");
        u_dout = 16'h1111;
        u_rx_ready = 1'b1;
        req_frame[FW +: FW] = 32'h00000789;
        req_valid = 2'b10;
        tick();
        check_eq("stale_accept", req_accept, 2'b10);
        req_valid = '0;
        f0 = rv_cnt;
        fc = fall_cnt;
        for (int k = 0; k < 100 && fall_cnt == fc; k++) tick();
        repeat (5) tick();
        check_eq("stale_ignored", rv_cnt, f0);
        check_eq("stale_hold_link", link_busy, 1);
        u_rx_ready = 1'b0;
        tick();
        check_eq("stale_low_no_resp", resp_valid, 0);
        u_dout = 16'h2222;
        u_rx_ready = 1'b1;
        tick();
        check_eq("stale_resp_valid", resp_valid, 2'b10);
        check_eq("stale_resp_data", resp_data, 16'h2222);
        u_rx_ready = 1'b0;
        tick();

        // Read with no RX response
        $display("txn read req0 with no response");
        req_frame[0 +: FW] = 32'h00000321;
        req_valid = 2'b01;
        tick();
        check_eq("to_accept", req_accept, 2'b01);
        req_valid = '0;
        fc = fall_cnt;
        for (int k = 0; k < 100 && fall_cnt == fc; k++) tick();
        fc = fall_cyc;
`ifdef UART_RESP_TIMEOUT_EN
        for (int k = 0; k < 200 && err_cnt == 0; k++) tick();
        check_eq("to_err_count", err_cnt, 1);
        check_eq("to_err_vec", err_vec, 2'b01);
        check_eq("to_err_latency", err_cyc - fc, 51);
        check_eq("to_idle", link_busy, 0);
        check_eq("to_resp_data_kept", resp_data, 16'h2222);
`else
        repeat (60) tick();
        check_eq("to_still_waiting", link_busy, 1);
        check_eq("to_no_err", resp_err, 0);
        check_eq("to_err_count", err_cnt, 0);
        u_dout = 16'h0BEE;
        u_rx_ready = 1'b1;
        tick();
        check_eq("to_late_resp", resp_valid, 2'b01);
        check_eq("to_late_data", resp_data, 16'h0BEE);
        u_rx_ready = 1'b0;
`endif
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
